aes256_unloading: RTL and testbench

- Receiving end of the byte-serial result interface of the AES-256 loading block.
- After the encryption core signals completion, this block issues one request per byte and captures the returned bytes. It reassembles all 16 bytes into the 128-bit ciphertext block.
- It presents the block downstream with a valid/ready handshake.
- It sits between the AES-256 loading top (po_next_val_ready, po_data) and the consumer of ciphertext blocks, and is also reused as the TB-side reference collector.

---
 rtl/aes256_pkg.sv | 27 ++
 rtl/aes256_byte_assembler.sv | 46 ++++
 rtl/aes256_unloading.sv | 118 +++++++++++
 tb/tb_aes256_unloading.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes256_pkg.sv
// aes256_pkg: shared types and constants for the AES-256 result unloader.
//   state_t      : unloader FSM state encoding (IDLE, REQ, WAIT, OUT)
//   AES_*        : block/byte geometry of a ciphertext block
//   tmo_cnt_w()  : width needed for a counter that reaches cycles-1
package aes256_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int AES_BLOCK_BITS      = 128;
  localparam int AES_BYTE_BITS       = 8;
  localparam int AES_BYTES_PER_BLOCK = 16;

  // Smallest width w (at least 1) with 2**w >= cycles, so a counter of that
  // width can hold every value 0..cycles-1.
  function automatic int tmo_cnt_w(input int cycles);
    int w;
    w = 1;
    while ((1 << w) < cycles) w++;
    return w;
  endfunction

endpackage

// File: rtl/aes256_byte_assembler.sv
// aes256_byte_assembler: 16-byte shift register that rebuilds a ciphertext
// block from a byte stream. Each captured byte enters at the LSB end, so the
// first byte of the block ends up in bits [127:120].
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : restart the byte count for a new block
//   i_capture  : shift i_data into the block this cycle
//   i_data     : incoming ciphertext byte
//   o_block    : assembled block
//   o_last     : the next capture completes the block
module aes256_byte_assembler
  import aes256_pkg::*;
#(
  parameter int BYTES_PER_BLOCK = AES_BYTES_PER_BLOCK
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_capture,
  input  logic [AES_BYTE_BITS-1:0]  i_data,
  output logic [AES_BLOCK_BITS-1:0] o_block,
  output logic                      o_last
);

  logic [3:0]                r_count;
  logic [AES_BLOCK_BITS-1:0] r_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_block <= '0;
    end else begin
      // The count holds at the final byte instead of wrapping; the next
      // block always starts with an explicit clear.
      if (i_clear)
        r_count <= '0;
      else if (i_capture && !o_last)
        r_count <= r_count + 4'd1;
      if (i_capture)
        r_block <= {r_block[AES_BLOCK_BITS-AES_BYTE_BITS-1:0], i_data};
    end
  end

  assign o_last  = (r_count == 4'(BYTES_PER_BLOCK - 1));
  assign o_block = r_block;

endmodule

// File: rtl/aes256_unloading.sv
// aes256_unloading: pulls a finished ciphertext out of the AES-256 loader one
// byte at a time and presents the reassembled 128-bit block downstream.
//   clk, rst           : clock, synchronous active-high reset
//   pi_enc_done        : core finished; start unloading (ignored unless idle)
//   po_next_val_req    : one-cycle request for the next byte
//   pi_next_val_ready  : loader answer, pi_data valid (only honoured in WAIT)
//   pi_data            : ciphertext byte
//   po_block_valid     : po_block holds a complete block
//   pi_block_ready     : downstream accepts the block
//   po_block           : reassembled block, first byte in [127:120]
//   po_busy            : unloader not idle
//   po_timeout         : a request went unanswered for TIMEOUT_CYCLES
//   po_overrun         : pi_enc_done seen while a transfer was in progress
module aes256_unloading
  import aes256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int BYTES_PER_BLOCK = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pi_enc_done,
  input  logic                      pi_next_val_ready,
  input  logic [AES_BYTE_BITS-1:0]  pi_data,
  output logic                      po_next_val_req,
  input  logic                      pi_block_ready,
  output logic                      po_block_valid,
  output logic [AES_BLOCK_BITS-1:0] po_block,
  output logic                      po_busy,
  output logic                      po_timeout,
  output logic                      po_overrun
);

  localparam int TW = tmo_cnt_w(TIMEOUT_CYCLES);

  if (BYTES_PER_BLOCK != AES_BYTES_PER_BLOCK) begin : g_bpb_check
    $error("aes256_unloading: BYTES_PER_BLOCK must be 16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
    $error("aes256_unloading: TIMEOUT_CYCLES must be >= 1");
  end

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tmo;
  logic            r_busy;
  logic            r_overrun;
  logic            w_clear;
  logic            w_capture;
  logic            w_timeout;
  logic            w_last;

  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (pi_enc_done) begin
          w_next  = REQ;
          w_clear = 1'b1;
        end
      end
      REQ: w_next = WAIT;
      WAIT: begin
        if (pi_next_val_ready) begin
          w_capture = 1'b1;
          w_next    = w_last ? OUT : REQ;
        end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      OUT: begin
        if (pi_block_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != IDLE);
      // A second completion during a transfer is flagged, never queued.
      r_overrun <= pi_enc_done && (r_state != IDLE);
      if (r_state == REQ)
        r_tmo <= '0;
      else if (r_state == WAIT && !pi_next_val_ready && !w_timeout)
        r_tmo <= r_tmo + TW'(1);
    end
  end

  aes256_byte_assembler #(
    .BYTES_PER_BLOCK (BYTES_PER_BLOCK)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_capture (w_capture),
    .i_data    (pi_data),
    .o_block   (po_block),
    .o_last    (w_last)
  );

  assign po_next_val_req = (r_state == REQ);
  assign po_block_valid  = (r_state == OUT);
  assign po_busy         = r_busy;
  assign po_timeout      = w_timeout;
  assign po_overrun      = r_overrun;

endmodule

// File: tb/tb_aes256_unloading.sv
module tb_aes256_unloading;

  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pi_enc_done = 1'b0;
  logic         pi_next_val_ready = 1'b0;
  logic [7:0]   pi_data = 8'h00;
  logic         pi_block_ready = 1'b0;
  logic         po_next_val_req;
  logic         po_block_valid;
  logic [127:0] po_block;
  logic         po_busy;
  logic         po_timeout;
  logic         po_overrun;

  aes256_unloading #(.TIMEOUT_CYCLES(64), .BYTES_PER_BLOCK(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .pi_enc_done       (pi_enc_done),
    .pi_next_val_ready (pi_next_val_ready),
    .pi_data           (pi_data),
    .po_next_val_req   (po_next_val_req),
    .pi_block_ready    (pi_block_ready),
    .po_block_valid    (po_block_valid),
    .po_block          (po_block),
    .po_busy           (po_busy),
    .po_timeout        (po_timeout),
    .po_overrun        (po_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard and event counters (written by monitor only)
  logic [127:0] exp_q[$];
  int req_cnt = 0, ovr_cnt = 0, tmo_cnt = 0, rise_cnt = 0, done_cnt = 0;
  int last_req_cyc = 0, last_tmo_cyc = 0, last_rise_cyc = 0;
  bit prev_valid = 0, prev_ready = 0;

  // loader model controls (written by main only)
  logic [7:0] ld_bytes[16];
  int ld_mode = 0;   // 0: answer after 1 cycle, 1: random 1..10, 2: after 4
  int ld_stop = 99;  // stop answering once this many bytes were sent
  bit spur_en = 0;
  int spur_idx = 5;
  // loader state (written by loader only)
  int ld_idx = 0;
  int ld_d = 1;
  bit ld_ab = 0;
  bit spur_done = 0;
  int t_enc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int cur(input int which);
    case (which)
      0: return req_cnt;
      1: return rise_cnt;
      2: return done_cnt;
      default: return tmo_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (cur(which) < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, 128'(cur(which) >= target), 128'd1);
  endtask

  task automatic pulse_enc();
    @(posedge clk); #1;
    pi_enc_done = 1'b1;
    t_enc = cyc;
    @(posedge clk); #1;
    pi_enc_done = 1'b0;
  endtask

  task automatic load_block(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) ld_bytes[i] = blk[127-8*i -: 8];
  endtask

  // Loader model: answers each request after a delay with the next byte.
  always begin
    @(negedge clk);
    if (!rst && pi_enc_done && !po_busy) begin
      ld_idx = 0;
      spur_done = 0;
    end else if (!rst && po_next_val_req && ld_idx < ld_stop && ld_idx < 16) begin
      case (ld_mode)
        0: ld_d = 1;
        1: ld_d = $urandom_range(1, 10);
        default: ld_d = 4;
      endcase
      ld_ab = 0;
      if (spur_en && !spur_done && ld_idx == spur_idx) begin
        pi_next_val_ready = 1'b1;
        pi_data = 8'hFF;
        spur_done = 1;
      end
      for (int c = 0; c < ld_d; c++) begin
        @(posedge clk); #2;
        pi_next_val_ready = 1'b0;
        if (rst) ld_ab = 1;
      end
      if (!ld_ab) begin
        pi_next_val_ready = 1'b1;
        pi_data = ld_bytes[ld_idx];
        ld_idx++;
        @(posedge clk); #2;
        pi_next_val_ready = 1'b0;
      end
    end
  end

  // Monitor: counts pulses and checks presented blocks against the queue.
  always begin
    @(negedge clk);
    if (rst) begin
      prev_valid = 0;
      prev_ready = 0;
    end else begin
      if (po_next_val_req) begin req_cnt++; last_req_cyc = cyc; end
      if (po_overrun) ovr_cnt++;
      if (po_timeout) begin tmo_cnt++; last_tmo_cyc = cyc; end
      if (po_block_valid && !prev_valid) begin rise_cnt++; last_rise_cyc = cyc; end
      if (prev_valid && !prev_ready)
        chk("valid_held_in_stall", 128'(po_block_valid), 128'd1);
      if (po_block_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_block: got %h with no block expected", po_block);
        end else begin
          chk("block", po_block, exp_q[0]);
          if (pi_block_ready) begin
            void'(exp_q.pop_front());
            done_cnt++;
          end
        end
      end
      prev_valid = po_block_valid;
      prev_ready = pi_block_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_req, base_ovr, base_tmo, base_rise, base_done, r8;
    logic [127:0] blk;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(po_block_valid), 128'd0);
    chk("rst_block", po_block, 128'd0);
    chk("rst_busy", 128'(po_busy), 128'd0);
    chk("rst_req", 128'(po_next_val_req), 128'd0);
    chk("rst_timeout", 128'(po_timeout), 128'd0);
    chk("rst_overrun", 128'(po_overrun), 128'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // T1: FIPS vector, immediate loader, ready held high
    ld_mode = 0;
    pi_block_ready = 1'b1;
    load_block(FIPS_CT);
    base_req = req_cnt; base_done = done_cnt;
    exp_q.push_back(FIPS_CT);
    pulse_enc();
    wait_cnt(0, base_req + 1, 20, "t1_first_req_wait");
    chk("t1_first_req_latency", 128'(last_req_cyc - t_enc), 128'd1);
    wait_cnt(2, base_done + 1, 200, "t1_block_wait");
    chk("t1_valid_latency", 128'(last_rise_cyc - t_enc), 128'd33);
    chk("t1_req_count", 128'(req_cnt - base_req), 128'd16);
    repeat (3) @(posedge clk);

    // T2: random loader delay, downstream stall of 5 cycles
    ld_mode = 1;
    pi_block_ready = 1'b0;
    base_rise = rise_cnt; base_done = done_cnt;
    exp_q.push_back(FIPS_CT);
    pulse_enc();
    wait_cnt(1, base_rise + 1, 400, "t2_valid_wait");
    repeat (5) @(posedge clk);
    #1;
    pi_block_ready = 1'b1;
    wait_cnt(2, base_done + 1, 20, "t2_block_wait");
    repeat (3) @(posedge clk);

    // T3: loader goes silent after 7 bytes -> timeout
    ld_mode = 0;
    ld_stop = 7;
    base_req = req_cnt; base_tmo = tmo_cnt; base_rise = rise_cnt;
    pulse_enc();
    wait_cnt(0, base_req + 8, 100, "t3_req8_wait");
    r8 = last_req_cyc;
    wait_cnt(3, base_tmo + 1, 150, "t3_timeout_wait");
    chk("t3_timeout_delay", 128'(last_tmo_cyc - r8), 128'd64);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_timeout_once", 128'(tmo_cnt - base_tmo), 128'd1);
    chk("t3_idle", 128'(po_busy), 128'd0);
    chk("t3_no_valid", 128'(rise_cnt - base_rise), 128'd0);
    ld_stop = 99;

    // T4: overrun during byte 3 wait, spurious ready in a REQ cycle
    ld_mode = 2;
    spur_en = 1;
    spur_idx = 5;
    base_req = req_cnt; base_ovr = ovr_cnt; base_done = done_cnt;
    exp_q.push_back(FIPS_CT);
    pulse_enc();
    wait_cnt(0, base_req + 4, 40, "t4_req4_wait");
    pulse_enc();
    wait_cnt(2, base_done + 1, 300, "t4_block_wait");
    chk("t4_overrun_count", 128'(ovr_cnt - base_ovr), 128'd1);
    chk("t4_req_count", 128'(req_cnt - base_req), 128'd16);
    spur_en = 0;
    repeat (3) @(posedge clk);

    // T5: reset during byte 10 wait, then a fresh all-A5 transfer
    base_req = req_cnt;
    pulse_enc();
    wait_cnt(0, base_req + 11, 200, "t5_req11_wait");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_valid", 128'(po_block_valid), 128'd0);
    chk("t5_rst_block", po_block, 128'd0);
    chk("t5_rst_busy", 128'(po_busy), 128'd0);
    chk("t5_rst_req", 128'(po_next_val_req), 128'd0);
    chk("t5_rst_timeout", 128'(po_timeout), 128'd0);
    chk("t5_rst_overrun", 128'(po_overrun), 128'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    blk = {16{8'hA5}};
    load_block(blk);
    base_done = done_cnt;
    exp_q.push_back({16{8'hA5}});
    pulse_enc();
    wait_cnt(2, base_done + 1, 300, "t5_block_wait");
    repeat (3) @(posedge clk);

    // T6: back-to-back blocks with random bytes
    ld_mode = 1;
    pi_block_ready = 1'b1;
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'($urandom);
    load_block(blk);
    exp_q.push_back(blk);
    base_req = req_cnt; base_ovr = ovr_cnt; base_rise = rise_cnt; base_done = done_cnt;
    pulse_enc();
    wait_cnt(1, base_rise + 1, 400, "t6_first_valid_wait");
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'($urandom);
    load_block(blk);
    exp_q.push_back(blk);
    pulse_enc();
    wait_cnt(2, base_done + 2, 400, "t6_second_block_wait");
    chk("t6_no_overrun", 128'(ovr_cnt - base_ovr), 128'd0);
    chk("t6_req_count", 128'(req_cnt - base_req), 128'd32);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
